multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM for the multi-cycle RV32I datapath. It decodes `opcode`/`f3`/`f7`, sequences fetch, decode, execute, memory and write-back, and drives every mux select and write enable of the datapath. All outputs are Moore outputs of the state register, except `pc_write` in BRANCH, which also depends on `zero`.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: instruction[6:0].
- `f3` in 3: instruction[14:12].
- `f7` in 7: instruction[31:25].
- `zero` in 1: ALU zero flag.
- `adr_src` out 1: memory address source. 0 = PC, 1 = result.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: IR load enable.
- `old_pc_write` out 1: old-PC load enable.
- `pc_write` out 1: PC load enable.
- `reg_write` out 1: register file write enable.
- `imm_src` out 3: immediate format. 000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_src_a` out 2: ALU A source. 0 PC, 1 old PC, 2 A register.
- `alu_src_b` out 2: ALU B source. 0 B register, 1 immediate, 2 constant 4.
- `alu_function` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR, 110 SLTU.
- `result_src` out 2: result source. 0 ALU-out register, 1 MDR, 2 ALU direct, 3 immediate.
- `halted` out 1: controller is parked in HALT.

## Operation
Every output is 0 unless a state below lists it.

**Opcodes**
- R 0110011, I-ALU 0010011, LW 0000011, SW 0100011.
- BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111.

**States**
- FETCH: adr_src=0, ir_write=1, old_pc_write=1, a=0, b=2, ADD, result_src=2, pc_write=1. Next: DECODE.
- DECODE: a=1, b=1, ADD. imm_src=J if JAL, else B; this latches the branch/JAL target into ALU-out. Next by opcode:
  - LW or SW → MEM_ADR
  - R → EXEC_R; I-ALU → EXEC_I
  - BR → BRANCH; JAL → JAL; JALR → JALR_CALC; LUI → LUI
  - any other opcode → unknown-opcode rule (see Configuration)
- MEM_ADR: a=2, b=1, ADD, imm_src=I for LW and S for SW. Next: MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: adr_src=1, result_src=0. Next: MEM_WB.
- MEM_WB: result_src=1, reg_write=1. Next: FETCH.
- MEM_WRITE: adr_src=1, result_src=0, mem_write=1. Next: FETCH.
- EXEC_R: a=2, b=0, function from the R-type decode. Next: ALU_WB.
- EXEC_I: a=2, b=1, imm_src=I, function from the I-type decode. Next: ALU_WB.
- ALU_WB: result_src=0, reg_write=1. Next: FETCH.
- BRANCH: a=2, b=0, result_src=0. Next: FETCH.
  - f3=000 BEQ: SUB, taken if zero.
  - f3=001 BNE: SUB, taken if !zero.
  - f3=100 BLT: SLT, taken if !zero.
  - f3=101 BGE: SLT, taken if zero.
  - pc_write = taken.
- JAL: result_src=0, pc_write=1, a=1, b=2, ADD. ALU-out captures old_pc+4. Next: ALU_WB.
- JALR_CALC: a=2, b=1, imm_src=I, ADD. Next: JALR_JUMP.
- JALR_JUMP: same outputs as JAL. Target bit 0 is not masked. Next: ALU_WB.
- LUI: imm_src=U, result_src=3, reg_write=1. Next: FETCH.
- HALT: halted=1, all enables 0. Next: HALT.

**R-type function decode**
- f3=000: ADD if f7[5]=0, SUB if f7[5]=1.
- 111 AND, 110 OR, 010 SLT, 011 SLTU, 100 XOR.

**I-type function decode**
- Same f3 mapping as R-type; f7 is ignored, so f3=000 is always ADD.
- Unlisted f3 (R, I or BR) takes the unknown-opcode rule.

## Timing
- CPI: FETCH is counted.
  - 3: BR, LUI
  - 4: R, I-ALU, SW, JAL
  - 5: LW, JALR
- `reset` high at an edge: state ← FETCH.
  - While `reset` is high, all enables (`mem_write`, `ir_write`, `reg_write`, `pc_write`, `old_pc_write`) are forced to 0 and `halted`=0.
  - Reset mid-instruction aborts it; no partial writes after that edge.
  - The first FETCH occurs in the first cycle with `reset` low.
- Branch `pc_write` is combinational from `zero`; the PC updates at the end of the BRANCH cycle.
- The target is still held in ALU-out during that cycle.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined: an unknown opcode, or an unlisted f3 for R/I/BR, goes DECODE→HALT. The controller stays there until `reset`.
- Undefined: such instructions go DECODE→FETCH, with no writes (a NOP, 2 cycles). HALT is unreachable and `halted` is tied to 0.

## Test plan
- Reset held 3 cycles, then released → cycle 1 is FETCH with ir_write=pc_write=old_pc_write=1. No enables are asserted during reset.
- `add x3,x1,x2` (0x002081B3) → states FETCH, DECODE, EXEC_R (func 000), ALU_WB (reg_write=1); 4 cycles. Same with f7=0100000 → func 001.
- `lw` (opcode 0000011) → MEM_READ with adr_src=1, then MEM_WB with result_src=1; 5 cycles. `sw` → mem_write=1 for exactly 1 cycle.
- BNE with zero=0 → pc_write=1 in BRANCH. BNE with zero=1 → pc_write=0. BGE with zero=1 → taken.
- `jal` → JAL state has pc_write=1 and result_src=0, then ALU_WB. `jalr` passes through JALR_CALC and JALR_JUMP; 5 cycles.
- Opcode 1111111: with the macro → halted=1 after DECODE, cleared by reset. Without the macro → back in FETCH after 2 cycles with no writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM; define MC_CTRL_ILLEGAL_TRAP_EN to park illegal instructions in HALT
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       old_pc_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_function,
  output logic [1:0] result_src,
  output logic       halted
);
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR_CALC = 4'd11;
  localparam logic [3:0] S_JALR_JUMP = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;
  localparam logic [3:0] S_HALT      = 4'd14;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] F_ADD  = 3'd0;
  localparam logic [2:0] F_SUB  = 3'd1;
  localparam logic [2:0] F_AND  = 3'd2;
  localparam logic [2:0] F_OR   = 3'd3;
  localparam logic [2:0] F_SLT  = 3'd4;
  localparam logic [2:0] F_XOR  = 3'd5;
  localparam logic [2:0] F_SLTU = 3'd6;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_ILLEGAL = S_HALT;
`else
  localparam logic [3:0] S_ILLEGAL = S_FETCH;
`endif

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] decode_next;
  logic [2:0] alu_fn;
  logic [2:0] br_fn;
  logic       alu_ok;
  logic       br_ok;
  logic       legal;
  logic       taken;
  logic       unused_f7;

  assign unused_f7 = ^{f7[6], f7[4:0]};

  // Decode the held instruction fields: ALU op, branch op/outcome, legality, DECODE successor
  always_comb begin
    alu_fn = f3 == 3'b111 ? F_AND :
             f3 == 3'b110 ? F_OR :
             f3 == 3'b010 ? F_SLT :
             f3 == 3'b011 ? F_SLTU :
             f3 == 3'b100 ? F_XOR : F_ADD;
    alu_ok = f3[1:0] != 2'b01;
    br_ok = !f3[1];
    br_fn = f3[2] ? F_SLT : F_SUB;
    taken = zero ^ (f3[2] ^ f3[0]);
    legal = (opcode == OP_R || opcode == OP_I) ? alu_ok :
            opcode == OP_BR ? br_ok :
            (opcode == OP_LW || opcode == OP_SW || opcode == OP_JAL ||
             opcode == OP_JALR || opcode == OP_LUI);
    decode_next = !legal ? S_ILLEGAL :
                  (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADR :
                  opcode == OP_R ? S_EXEC_R :
                  opcode == OP_I ? S_EXEC_I :
                  opcode == OP_BR ? S_BRANCH :
                  opcode == OP_JAL ? S_JAL :
                  opcode == OP_JALR ? S_JALR_CALC : S_LUI;
  end

  // Next-state sequencing; HALT is a sink only when trapping is built in
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = decode_next;
      S_MEM_ADR:   state_d = opcode == OP_SW ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXEC_R,
      S_EXEC_I,
      S_JAL,
      S_JALR_JUMP: state_d = S_ALU_WB;
      S_JALR_CALC: state_d = S_JALR_JUMP;
      S_HALT:      state_d = S_ILLEGAL;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register; reset restarts at FETCH
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;

  // Moore datapath controls per state; all write enables are suppressed while reset is high
  always_comb begin
    adr_src = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    old_pc_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    imm_src = IMM_I;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_function = F_ADD;
    result_src = 2'd0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        old_pc_write = 1'b1;
        pc_write = 1'b1;
        alu_src_b = 2'd2;
        result_src = 2'd2;
      end
      S_DECODE: begin
        imm_src = opcode == OP_JAL ? IMM_J : IMM_B;
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      S_MEM_ADR: begin
        imm_src = opcode == OP_SW ? IMM_S : IMM_I;
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_MEM_READ: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = 2'd1;
        reg_write = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_function = (f3 == 3'b000 && f7[5]) ? F_SUB : alu_fn;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_function = alu_fn;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_function = br_fn;
        pc_write = taken;
      end
      S_JAL,
      S_JALR_JUMP: begin
        pc_write = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
      end
      S_JALR_CALC: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_LUI: begin
        imm_src = IMM_U;
        result_src = 2'd3;
        reg_write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      mem_write = 1'b0;
      ir_write = 1'b0;
      old_pc_write = 1'b0;
      pc_write = 1'b0;
      reg_write = 1'b0;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign halted = state_q == S_HALT && !reset;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-instruction control-vector checks for multicycle_controller
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic [6:0] f7 = 7'd0;
  logic       zero = 1'b0;
  logic       adr_src, mem_write, ir_write, old_pc_write, pc_write, reg_write, halted;
  logic [2:0] imm_src, alu_function;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [18:0] ctl;
  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // {adr,mw,irw,opw,pcw,rw}, imm, a, b, fn, rs, halted
  localparam logic [18:0] E_FETCH = {6'b001110, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0};
  localparam logic [18:0] E_RST   = {6'b000000, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0};
  localparam logic [18:0] E_DEC_B = {6'b000000, 3'd2, 2'd1, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_DEC_J = {6'b000000, 3'd3, 2'd1, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_MA_I  = {6'b000000, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_MA_S  = {6'b000000, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_MRD   = {6'b100000, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_MWB   = {6'b000001, 3'd0, 2'd0, 2'd0, 3'd0, 2'd1, 1'b0};
  localparam logic [18:0] E_MWR   = {6'b110000, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_AWB   = {6'b000001, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_JAL   = {6'b000010, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_JCALC = {6'b000000, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] E_LUI   = {6'b000001, 3'd4, 2'd0, 2'd0, 3'd0, 2'd3, 1'b0};
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [18:0] E_HALT  = {6'b000000, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1};
`endif

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .f3(f3), .f7(f7), .zero(zero),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .old_pc_write(old_pc_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_function(alu_function), .result_src(result_src), .halted(halted)
  );

  assign ctl = {adr_src, mem_write, ir_write, old_pc_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, alu_function, result_src, halted};

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== E_RST) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b expected %b", i, ctl, E_RST);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_r(input logic [2:0] f, input logic [6:0] g, input logic [2:0] fn);
    logic [18:0] e [4];
    opcode = OP_R; f3 = f; f7 = g;
    e[0] = E_FETCH; e[1] = E_DEC_B;
    e[2] = {6'b000000, 3'd0, 2'd2, 2'd0, fn, 2'd0, 1'b0};
    e[3] = E_AWB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL r_type f3=%b f7=%b [%0d]: got %b expected %b", f, g, i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_i(input logic [2:0] f, input logic [6:0] g, input logic [2:0] fn);
    logic [18:0] e [4];
    opcode = OP_I; f3 = f; f7 = g;
    e[0] = E_FETCH; e[1] = E_DEC_B;
    e[2] = {6'b000000, 3'd0, 2'd2, 2'd1, fn, 2'd0, 1'b0};
    e[3] = E_AWB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL i_type f3=%b f7=%b [%0d]: got %b expected %b", f, g, i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [18:0] e [5];
    opcode = OP_LW; f3 = 3'b010; f7 = 7'd0;
    e[0] = E_FETCH; e[1] = E_DEC_B; e[2] = E_MA_I; e[3] = E_MRD; e[4] = E_MWB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL lw[%0d]: got %b expected %b", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [18:0] e [4];
    opcode = OP_SW; f3 = 3'b010; f7 = 7'd0;
    e[0] = E_FETCH; e[1] = E_DEC_B; e[2] = E_MA_S; e[3] = E_MWR;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL sw[%0d]: got %b expected %b", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_branch(input logic [2:0] f, input logic z, input logic [2:0] fn, input logic tk);
    logic [18:0] e [3];
    opcode = OP_BR; f3 = f; f7 = 7'd0; zero = z;
    e[0] = E_FETCH; e[1] = E_DEC_B;
    e[2] = {4'b0000, tk, 1'b0, 3'd0, 2'd2, 2'd0, fn, 2'd0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL branch f3=%b zero=%b [%0d]: got %b expected %b", f, z, i, ctl, e[i]);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [18:0] e [4];
    opcode = OP_JAL; f3 = 3'd0; f7 = 7'd0;
    e[0] = E_FETCH; e[1] = E_DEC_J; e[2] = E_JAL; e[3] = E_AWB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL jal[%0d]: got %b expected %b", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_jalr();
    logic [18:0] e [5];
    opcode = OP_JALR; f3 = 3'd0; f7 = 7'd0;
    e[0] = E_FETCH; e[1] = E_DEC_B; e[2] = E_JCALC; e[3] = E_JAL; e[4] = E_AWB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL jalr[%0d]: got %b expected %b", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_lui();
    logic [18:0] e [3];
    opcode = OP_LUI; f3 = 3'd5; f7 = 7'd0;
    e[0] = E_FETCH; e[1] = E_DEC_B; e[2] = E_LUI;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL lui[%0d]: got %b expected %b", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_illegal(input logic [6:0] op, input logic [2:0] f);
    logic [18:0] e [5];
    opcode = op; f3 = f; f7 = 7'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    e[0] = E_FETCH; e[1] = E_DEC_B; e[2] = E_HALT; e[3] = E_HALT; e[4] = E_HALT;
`else
    e[0] = E_FETCH; e[1] = E_DEC_B; e[2] = E_FETCH; e[3] = E_DEC_B; e[4] = E_LUI;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL illegal op=%b f3=%b [%0d]: got %b expected %b", op, f, i, ctl, e[i]);
      end
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      if (i == 2) begin
        opcode = OP_LUI;
        f3 = 3'd0;
      end
`endif
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== E_RST) begin
      miscompares++;
      $display("FAIL halt_clear: got %b expected %b", ctl, E_RST);
    end
    @(posedge clk);
    #1 reset = 1'b0;
`endif
  endtask

  task automatic test_reset_abort();
    logic [18:0] e [3];
    opcode = OP_SW; f3 = 3'b010; f7 = 7'd0;
    e[0] = E_FETCH; e[1] = E_DEC_B; e[2] = E_MA_S;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== e[i]) begin
        miscompares++;
        $display("FAIL abort[%0d]: got %b expected %b", i, ctl, e[i]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== E_RST) begin
      miscompares++;
      $display("FAIL abort_reset: got %b expected %b", ctl, E_RST);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_r(3'b000, 7'b0000000, 3'd0);
    test_r(3'b000, 7'b0100000, 3'd1);
    test_r(3'b111, 7'b0000000, 3'd2);
    test_r(3'b011, 7'b0000000, 3'd6);
    test_i(3'b000, 7'b0100000, 3'd0);
    test_i(3'b100, 7'b0000000, 3'd5);
    test_i(3'b110, 7'b0000000, 3'd3);
    test_load();
    test_store();
    test_branch(3'b000, 1'b1, 3'd1, 1'b1);
    test_branch(3'b001, 1'b0, 3'd1, 1'b1);
    test_branch(3'b001, 1'b1, 3'd1, 1'b0);
    test_branch(3'b100, 1'b0, 3'd4, 1'b1);
    test_branch(3'b101, 1'b1, 3'd4, 1'b1);
    test_branch(3'b101, 1'b0, 3'd4, 1'b0);
    test_jal();
    test_jalr();
    test_lui();
    test_illegal(7'b1111111, 3'b000);
    test_illegal(OP_R, 3'b001);
    test_illegal(OP_BR, 3'b010);
    test_reset_abort();
    test_lui();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
